// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and UART TX handshake shared by the arbiter and its environment.
// Signal names carry the arbiter's direction: i_ into the arbiter, o_ out of it.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   i_req_valid;
    logic [8*N_REQ-1:0] i_req_data;
    logic [N_REQ-1:0]   i_req_last;
    logic [N_REQ-1:0]   o_req_ready;
    logic               o_tx_dv;
    logic [7:0]         o_tx_byte;
    logic               i_tx_active;
    logic               i_tx_done;

    modport master (
        input  i_req_valid, i_req_data, i_req_last, i_tx_active, i_tx_done,
        output o_req_ready, o_tx_dv, o_tx_byte
    );

    modport slave (
        output i_req_valid, i_req_data, i_req_last, i_tx_active, i_tx_done,
        input  o_req_ready, o_tx_dv, o_tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among N_REQ byte streams, with packet lock,
// burst limit and a watchdog that recovers from a TX that never reports done.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned TIMEOUT_CLKS = 2604
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus,
    output logic [2:0]        o_grant_id,
    output logic              o_busy,
    output logic              o_timeout
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {IDLE, ACCEPT, LAUNCH, WAIT_DONE} state_t;

    state_t          r_state;
    logic [2:0]      r_ptr;
    logic [2:0]      r_grant;
    logic [7:0]      r_burst;
    logic [WD_W-1:0] r_wd;
    logic            r_last;
    logic [7:0]      r_tx_byte;
    logic            r_tx_dv;
    logic            r_busy;
    logic            r_timeout;

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [2:0]         w_off;
    logic [3:0]         w_sum;
    logic [2:0]         w_sel;
    logic               w_any;
    logic               w_g_valid;
    logic [7:0]         w_g_data;
    logic               w_g_last;
    logic [2:0]         w_next_ptr;
    logic               w_more;

    // Rotate valids so bit 0 is the pointer position; lowest set bit wins.
    always_comb begin
        w_dbl = {bus.i_req_valid, bus.i_req_valid} >> r_ptr;
        w_rot = w_dbl[N_REQ-1:0];
        w_any = 1'b0;
        w_off = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (w_rot[j] && !w_any) begin
                w_any = 1'b1;
                w_off = 3'(j);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        w_sel = (w_sum >= 4'(N_REQ)) ? 3'(w_sum - 4'(N_REQ)) : w_sum[2:0];
    end

    always_comb begin
        w_g_valid       = 1'b0;
        w_g_data        = '0;
        w_g_last        = 1'b0;
        bus.o_req_ready = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r_grant == 3'(k)) begin
                w_g_valid          = bus.i_req_valid[k];
                w_g_data           = bus.i_req_data[8*k +: 8];
                w_g_last           = bus.i_req_last[k];
                bus.o_req_ready[k] = (r_state == ACCEPT) && bus.i_req_valid[k];
            end
        end
        w_next_ptr = (r_grant == 3'(N_REQ - 1)) ? '0 : r_grant + 3'd1;
        w_more     = !r_last && (r_burst < 8'(MAX_BURST)) && w_g_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_burst   <= '0;
            r_wd      <= '0;
            r_last    <= 1'b0;
            r_tx_byte <= '0;
            r_tx_dv   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_tx_dv   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any && !bus.i_tx_active) begin
                        r_grant <= w_sel;
                        r_burst <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (w_g_valid) begin
                        r_tx_byte <= w_g_data;
                        r_last    <= w_g_last;
                        if (r_burst < 8'(MAX_BURST)) r_burst <= r_burst + 8'd1;
                        r_tx_dv   <= 1'b1;
                        r_state   <= LAUNCH;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                LAUNCH: begin
                    // The dv cycle itself counts toward the timeout window.
                    r_wd    <= WD_W'(1);
                    r_state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.i_tx_done) begin
                        if (w_more) begin
                            r_state <= ACCEPT;
                        end else begin
                            r_ptr   <= w_next_ptr;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (r_wd == WD_W'(TIMEOUT_CLKS - 1)) begin
                        r_timeout <= 1'b1;
                        r_ptr     <= w_next_ptr;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_tx_dv   = r_tx_dv;
    assign bus.o_tx_byte = r_tx_byte;
    assign o_grant_id    = r_grant;
    assign o_busy        = r_busy;
    assign o_timeout     = r_timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a UART TX model are stepped
// on every falling edge; each launched byte is matched against the expected grant/byte.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int unsigned N      = 4;
    localparam int unsigned TMO    = 2604;
    localparam int          TX_LEN = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] grant_id;
    logic       busy;
    logic       timeout;

    uart_tx_arbiter_if #(.N_REQ(N)) bus();

    uart_tx_arbiter #(
        .N_REQ       (N),
        .MAX_BURST   (4),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .o_grant_id(grant_id),
        .o_busy    (busy),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] rq [N][$];   // {last, byte} per requester
    logic [10:0] sb [$];     // {grant, byte} in expected TX order
    logic [N-1:0] hs = '0;
    int         tx_cnt = 0;
    bit         tx_stall = 1'b0;
    int         cyc = 0;
    int         dv_cyc = 0;

    // One falling-edge step: retire handshakes, run TX model, monitor dv, drive requesters.
    task automatic tick();
        logic [10:0] exp;
        logic [8:0]  f;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            hs = '0;
            tx_cnt = 0;
            bus.i_tx_done = 1'b0;
            bus.i_tx_active = 1'b0;
        end else begin
            for (int k = 0; k < N; k++)
                if (hs[k] && rq[k].size() != 0) void'(rq[k].pop_front());
            bus.i_tx_done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    bus.i_tx_done = !tx_stall;
                    bus.i_tx_active = 1'b0;
                end
            end
            if (bus.o_tx_dv === 1'b1) begin
                dv_cyc = cyc;
                tx_cnt = TX_LEN;
                bus.i_tx_active = 1'b1;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL tx_unexpected: got grant %0d byte %02h, expected no launch",
                             grant_id, bus.o_tx_byte);
                end else begin
                    exp = sb.pop_front();
                    if ({grant_id, bus.o_tx_byte} !== exp)
                        $display("FAIL tx_byte: got grant %0d byte %02h, expected grant %0d byte %02h",
                                 grant_id, bus.o_tx_byte, exp[10:8], exp[7:0]);
                    else
                        n_pass++;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() != 0) begin
                f = rq[k][0];
                bus.i_req_valid[k]        = 1'b1;
                bus.i_req_data[8*k +: 8]  = f[7:0];
                bus.i_req_last[k]         = f[8];
            end else begin
                bus.i_req_valid[k]        = 1'b0;
                bus.i_req_data[8*k +: 8]  = 8'h00;
                bus.i_req_last[k]         = 1'b0;
            end
        end
        #1;
        hs = rst_n ? (bus.o_req_ready & bus.i_req_valid) : '0;
        if (rst_n && bus.o_req_ready != '0) begin
            n_checks++;
            if ((bus.o_req_ready & (bus.o_req_ready - 1'b1)) != '0 ||
                bus.o_req_ready !== (4'b0001 << grant_id))
                $display("FAIL ready_onehot: got ready %b grant %0d, expected only grant bit",
                         bus.o_req_ready, grant_id);
            else
                n_pass++;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tx_stall = 1'b0;
        for (int k = 0; k < N; k++) rq[k].delete();
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (sb.size() == 0 && busy === 1'b0 && tx_cnt == 0 &&
                rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0)
                done = 1'b1;
        end
        n_checks++;
        if (!done)
            $display("FAIL %s_drain: got %0d bytes outstanding busy %b, expected all sent within %0d cycles",
                     name, sb.size(), busy, budget);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({bus.o_tx_dv, bus.o_tx_byte} !== 9'h000)
            $display("FAIL reset_tx: got dv %b byte %02h, expected 0 00", bus.o_tx_dv, bus.o_tx_byte);
        else n_pass++;
        n_checks++;
        if ({grant_id, busy, timeout} !== 5'b0)
            $display("FAIL reset_status: got grant %0d busy %b timeout %b, expected 0 0 0",
                     grant_id, busy, timeout);
        else n_pass++;
        n_checks++;
        if (bus.o_req_ready !== 4'b0000)
            $display("FAIL reset_ready: got %b expected 0000", bus.o_req_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        reset_dut();
        rq[0].push_back({1'b1, 8'h37});
        sb.push_back({3'd0, 8'h37});
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL single_idle: got busy %b expected 0", busy);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.o_req_ready !== 4'b0001 || bus.o_tx_dv !== 1'b0)
            $display("FAIL single_ready: got ready %b dv %b, expected 0001 0", bus.o_req_ready, bus.o_tx_dv);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 3'd0)
            $display("FAIL single_grant: got busy %b grant %0d, expected 1 0", busy, grant_id);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.o_tx_dv !== 1'b1 || bus.o_req_ready !== 4'b0000)
            $display("FAIL single_dv: got dv %b ready %b, expected 1 0000", bus.o_tx_dv, bus.o_req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.o_tx_dv !== 1'b0) $display("FAIL single_dv_pulse: got %b expected 0", bus.o_tx_dv);
        else n_pass++;
        wait_idle(100, "single");
        n_checks++;
        if (bus.o_tx_byte !== 8'h37 || busy !== 1'b0)
            $display("FAIL single_hold: got byte %02h busy %b, expected 37 0", bus.o_tx_byte, busy);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b;
            b = 8'hA0 + 8'(k);
            rq[k].push_back({1'b1, b});
            sb.push_back({3'(k), b});
        end
        wait_idle(200, "round_robin");
    endtask

    task automatic test_packet_lock();
        reset_dut();
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        sb.push_back({3'd1, 8'h11});
        sb.push_back({3'd1, 8'h22});
        sb.push_back({3'd1, 8'h33});
        sb.push_back({3'd0, 8'h44});
        tick();
        tick();
        n_checks++;
        if (grant_id !== 3'd1) $display("FAIL lock_grant: got %0d expected 1", grant_id);
        else n_pass++;
        rq[0].push_back({1'b1, 8'h44});
        wait_idle(300, "packet_lock");
    endtask

    task automatic test_burst_limit();
        reset_dut();
        for (int i = 0; i < 6; i++) rq[2].push_back({1'b0, 8'h60 + 8'(i)});
        rq[3].push_back({1'b1, 8'h70});
        for (int i = 0; i < 4; i++) sb.push_back({3'd2, 8'h60 + 8'(i)});
        sb.push_back({3'd3, 8'h70});
        sb.push_back({3'd2, 8'h64});
        sb.push_back({3'd2, 8'h65});
        wait_idle(400, "burst_limit");
    endtask

    task automatic test_timeout();
        bit got = 1'b0;
        reset_dut();
        tx_stall = 1'b1;
        rq[0].push_back({1'b1, 8'h5A});
        rq[1].push_back({1'b1, 8'h5B});
        sb.push_back({3'd0, 8'h5A});
        sb.push_back({3'd1, 8'h5B});
        for (int i = 0; i < int'(TMO) + 200 && !got; i++) begin
            tick();
            if (timeout === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) $display("FAIL timeout_seen: got no o_timeout pulse, expected one");
        else n_pass++;
        n_checks++;
        if (cyc - dv_cyc !== int'(TMO))
            $display("FAIL timeout_delay: got %0d clks after dv, expected %0d", cyc - dv_cyc, TMO);
        else n_pass++;
        tx_stall = 1'b0;
        tick();
        n_checks++;
        if (timeout !== 1'b0 || grant_id !== 3'd1)
            $display("FAIL timeout_next: got timeout %b grant %0d, expected 0 1", timeout, grant_id);
        else n_pass++;
        wait_idle(200, "timeout");
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        reset_dut();
        rq[1].push_back({1'b1, 8'h82});
        rq[2].push_back({1'b1, 8'h83});
        sb.push_back({3'd1, 8'h82});
        sb.push_back({3'd2, 8'h83});
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (sb.size() == 0) seen = 1'b1;
        end
        tick();
        tick();
        n_checks++;
        if (!seen || busy !== 1'b1 || grant_id !== 3'd2)
            $display("FAIL midrst_pre: got seen %b busy %b grant %0d, expected 1 1 2", seen, busy, grant_id);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_tx_dv, bus.o_tx_byte, grant_id, busy, timeout, bus.o_req_ready} !== '0)
            $display("FAIL midrst_outputs: got dv %b byte %02h grant %0d busy %b timeout %b ready %b, expected all 0",
                     bus.o_tx_dv, bus.o_tx_byte, grant_id, busy, timeout, bus.o_req_ready);
        else n_pass++;
        for (int k = 0; k < N; k++) rq[k].delete();
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        rq[3].push_back({1'b1, 8'h93});
        rq[1].push_back({1'b1, 8'h91});
        sb.push_back({3'd1, 8'h91});
        sb.push_back({3'd3, 8'h93});
        wait_idle(200, "midrst");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_limit: got no finish by 1 ms, expected bench to complete");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_burst_limit();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
